// File: rtl/iob_sram_responder_pkg.sv
// iob_sram_responder_pkg: shared state encoding, bus byte width and parameter clamp helper
package iob_sram_responder_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RDLAT} state_e;
  function automatic int clamp(input int v, input int lo, input int hi);
    return v < lo ? lo : v > hi ? hi : v;
  endfunction
endpackage

// File: rtl/iob_sram_responder_ram.sv
// iob_sram_responder_ram: single-port byte-enable SRAM with registered read
//   clk_i   clock
//   en_i    access strobe (one per accepted request)
//   we_i    byte write strobes; all zero = read
//   addr_i  word index
//   wdata_i write data
//   rdata_o read data, holds until the next read access
module iob_sram_responder_ram import iob_sram_responder_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int AW     = 12
) (
  input  logic                     clk_i,
  input  logic                     en_i,
  input  logic [DATA_W/BYTE_W-1:0] we_i,
  input  logic [AW-1:0]            addr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o
);
  logic [DATA_W-1:0] mem_q [2**AW];
  logic [DATA_W-1:0] rdata_q;
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int i = 0; i < DATA_W/BYTE_W; i++)
        if (we_i[i]) mem_q[addr_i][i*BYTE_W +: BYTE_W] <= wdata_i[i*BYTE_W +: BYTE_W];
      if (we_i == '0) rdata_q <= mem_q[addr_i];
    end
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/iob_sram_responder.sv
// iob_sram_responder: IOb native-bus SRAM responder with fixed read latency and injected wait states
//   clk_i, rst_i (async, active-high), cke_i (0 freezes everything)
//   iob_avalid_i/iob_addr_i/iob_wdata_i/iob_wstrb_i  request (wstrb 0 = read)
//   iob_ready_o   accept when avalid=1
//   iob_rvalid_o  one-cycle read data pulse, READ_LAT cycles after accept
//   iob_rdata_o   read data, held between pulses
module iob_sram_responder import iob_sram_responder_pkg::*; #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 14,
  parameter int READ_LAT = 1,
  parameter int WAIT_CYC = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cke_i,
  input  logic                     iob_avalid_i,
  input  logic [ADDR_W-1:0]        iob_addr_i,
  input  logic [DATA_W-1:0]        iob_wdata_i,
  input  logic [DATA_W/BYTE_W-1:0] iob_wstrb_i,
  output logic                     iob_ready_o,
  output logic                     iob_rvalid_o,
  output logic [DATA_W-1:0]        iob_rdata_o
);
  localparam int RL = clamp(READ_LAT, 1, 4);
  localparam int WC = clamp(WAIT_CYC, 0, 15);
  localparam logic [2:0] RD_INIT = 3'(RL);
  localparam logic [3:0] WS_INIT = 4'(WC > 0 ? WC - 1 : 0);
  localparam logic NO_WAIT = WC == 0;
  state_e state_q, state_d;
  logic [3:0] ws_cnt_q, ws_cnt_d;
  logic [2:0] rd_cnt_q, rd_cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, ram_rdata;
  logic rd_last, accept, is_rd, unused_addr;
  assign unused_addr = ^iob_addr_i[1:0];
  // The RAM read register holds its word until the next read, and only one
  // read is ever outstanding, so it doubles as the latency delay line.
  iob_sram_responder_ram #(.DATA_W(DATA_W), .AW(ADDR_W-2)) u_ram (
    .clk_i  (clk_i),
    .en_i   (accept),
    .we_i   (iob_wstrb_i),
    .addr_i (iob_addr_i[ADDR_W-1:2]),
    .wdata_i(iob_wdata_i),
    .rdata_o(ram_rdata)
  );
  always_comb begin
    rd_last = state_q == S_RDLAT && rd_cnt_q == 3'd1;
    iob_ready_o = state_q == S_WAIT ? ws_cnt_q == '0 : state_q == S_RDLAT ? rd_last && NO_WAIT : NO_WAIT;
    accept = iob_avalid_i && iob_ready_o && cke_i;
    is_rd = iob_wstrb_i == '0;
    iob_rvalid_o = rd_last;
    iob_rdata_o = rd_last ? ram_rdata : rdata_q;
    rdata_d = iob_rdata_o;
    state_d = state_q;
    ws_cnt_d = ws_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (state_q == S_RDLAT && !rd_last) rd_cnt_d = rd_cnt_q - 3'd1;
    else if (accept) begin
      state_d = is_rd ? S_RDLAT : S_IDLE;
      rd_cnt_d = is_rd ? RD_INIT : '0;
      ws_cnt_d = '0;
    end else if (state_q == S_WAIT) begin
      // avalid dropping before accept abandons the request without side effects
      state_d = iob_avalid_i ? S_WAIT : S_IDLE;
      ws_cnt_d = iob_avalid_i && ws_cnt_q != '0 ? ws_cnt_q - 4'd1 : '0;
    end else if (iob_avalid_i && !NO_WAIT) begin
      // the IDLE cycle itself is the first ready-low cycle
      state_d = S_WAIT;
      ws_cnt_d = WS_INIT;
      rd_cnt_d = '0;
    end else begin
      state_d = S_IDLE;
      rd_cnt_d = '0;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ws_cnt_q <= '0;
      rd_cnt_q <= '0;
      rdata_q <= '0;
    end else if (cke_i) begin
      state_q <= state_d;
      ws_cnt_q <= ws_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      rdata_q <= rdata_d;
    end
  end
endmodule
